// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the Mini SRC datapath.
// Steps RESET -> T0..T7 -> T0 (or HALT), decoding the IR opcode in T3.
// Ports:
//   clk, clr (sync active-high reset), ir[31:0] (opcode ir[31:27]),
//   con_out (branch condition), datapath strobes (1 bit each),
//   alu_op[4:0] (ALU select), run (high while executing).
module control_sequencer #(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_out,
  output logic        pc_out,
  output logic        zlo_out,
  output logic        zhi_out,
  output logic        hi_out,
  output logic        lo_out,
  output logic        mdr_out,
  output logic        inport_out,
  output logic        c_sign_extended_out,
  output logic        ba_out,
  output logic        r_out,
  output logic        r_in,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        mar_enable,
  output logic        mdr_enable,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        z_enable,
  output logic        pc_enable,
  output logic        pc_increment,
  output logic        hi_enable,
  output logic        lo_enable,
  output logic        outport_enable,
  output logic        con_enable,
  output logic        read,
  output logic        ram_write,
  output logic [4:0]  alu_op,
  output logic        run
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned CNT_W = 2;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [OP_W-1:0]  opcode_q;
  logic [OP_W-1:0]  op;
  logic             is_ld, is_ldi, is_st, is_alu_r, is_alu_i, is_br;
  logic             is_in, is_out, is_mfhi, is_mflo, is_halt, is_addr;
  logic             ir_unused;

  // Only the opcode field of the IR steers the sequence.
  assign ir_unused = ^ir[26:0];

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= S_RESET;
    else     state <= state_nxt;
  end

  // Reset hold counter (reloads while clr is held) and opcode latch (T3).
  always_ff @(posedge clk) begin
    if (clr) begin
      hold_cnt <= CNT_W'(RESET_PC_HOLD);
      opcode_q <= OP_NOP;
    end else begin
      if (state == S_RESET && hold_cnt != '0) hold_cnt <= hold_cnt - CNT_W'(1);
      if (state == S_T3) opcode_q <= ir[31:27];
    end
  end

  // In T3 the IR was just loaded, so decode it directly; later steps use the latch.
  always_comb begin
    op       = (state == S_T3) ? ir[31:27] : opcode_q;
    is_ld    = (op == OP_LD);
    is_ldi   = (op == OP_LDI);
    is_st    = (op == OP_ST);
    is_alu_r = (op >= OP_ADD) && (op <= OP_OR);
    is_alu_i = (op >= OP_ADDI) && (op <= OP_ORI);
    is_br    = (op == OP_BR);
    is_in    = (op == OP_IN);
    is_out   = (op == OP_OUT);
    is_mfhi  = (op == OP_MFHI);
    is_mflo  = (op == OP_MFLO);
    is_halt  = (op == OP_HALT);
    is_addr  = is_ld | is_ldi | is_st;
  end

  // Next-state logic; undefined opcodes fall through like nop.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: if (hold_cnt == '0) state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3: begin
        if (is_halt)                                      state_nxt = S_HALT;
        else if (is_addr || is_alu_r || is_alu_i || is_br) state_nxt = S_T4;
        else                                              state_nxt = S_T0;
      end
      S_T4:    state_nxt = S_T5;
      S_T5:    state_nxt = (is_ld || is_st || is_br) ? S_T6 : S_T0;
      S_T6:    state_nxt = is_br ? S_T0 : S_T7;
      S_T7:    state_nxt = S_T0;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  // Output decode of state and opcode.
  always_comb begin
    pc_out = 1'b0;  zlo_out = 1'b0;  zhi_out = 1'b0;  hi_out = 1'b0;
    lo_out = 1'b0;  mdr_out = 1'b0;  inport_out = 1'b0;
    c_sign_extended_out = 1'b0;  ba_out = 1'b0;  r_out = 1'b0;  r_in = 1'b0;
    gra = 1'b0;  grb = 1'b0;  grc = 1'b0;
    mar_enable = 1'b0;  mdr_enable = 1'b0;  ir_enable = 1'b0;
    y_enable = 1'b0;  z_enable = 1'b0;  pc_enable = 1'b0;  pc_increment = 1'b0;
    hi_enable = 1'b0;  lo_enable = 1'b0;  outport_enable = 1'b0;
    con_enable = 1'b0;  read = 1'b0;  ram_write = 1'b0;
    alu_op = '0;
    run    = 1'b0;
    case (state)
      S_T0: begin
        run = 1'b1;
        pc_out = 1'b1;  mar_enable = 1'b1;  pc_increment = 1'b1;  z_enable = 1'b1;
      end
      S_T1: begin
        run = 1'b1;
        zlo_out = 1'b1;  pc_enable = 1'b1;  read = 1'b1;  mdr_enable = 1'b1;
      end
      S_T2: begin
        run = 1'b1;
        mdr_out = 1'b1;  ir_enable = 1'b1;
      end
      S_T3: begin
        // halt drops run as soon as it is decoded
        run = !is_halt;
        if (is_addr) begin
          grb = 1'b1;  ba_out = 1'b1;  y_enable = 1'b1;
        end else if (is_alu_r || is_alu_i) begin
          grb = 1'b1;  r_out = 1'b1;  y_enable = 1'b1;
        end else if (is_br) begin
          gra = 1'b1;  r_out = 1'b1;  con_enable = 1'b1;
        end else if (is_in) begin
          inport_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
        end else if (is_out) begin
          gra = 1'b1;  r_out = 1'b1;  outport_enable = 1'b1;
        end else if (is_mfhi) begin
          hi_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
        end else if (is_mflo) begin
          lo_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
        end
      end
      S_T4: begin
        run = 1'b1;
        if (is_addr) begin
          c_sign_extended_out = 1'b1;  z_enable = 1'b1;  alu_op = OP_ADD;
        end else if (is_alu_r) begin
          grc = 1'b1;  r_out = 1'b1;  z_enable = 1'b1;  alu_op = op;
        end else if (is_alu_i) begin
          c_sign_extended_out = 1'b1;  z_enable = 1'b1;  alu_op = op;
        end else if (is_br) begin
          pc_out = 1'b1;  y_enable = 1'b1;  alu_op = OP_ADD;
        end
      end
      S_T5: begin
        run = 1'b1;
        if (is_ld || is_st) begin
          zlo_out = 1'b1;  mar_enable = 1'b1;  alu_op = OP_ADD;
        end else if (is_ldi) begin
          zlo_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;  alu_op = OP_ADD;
        end else if (is_alu_r || is_alu_i) begin
          zlo_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
        end else if (is_br) begin
          c_sign_extended_out = 1'b1;  z_enable = 1'b1;  alu_op = OP_ADD;
        end
      end
      S_T6: begin
        run = 1'b1;
        if (is_ld) begin
          read = 1'b1;  mdr_enable = 1'b1;
        end else if (is_st) begin
          gra = 1'b1;  r_out = 1'b1;  mdr_enable = 1'b1;
        end else if (is_br && con_out) begin
          zlo_out = 1'b1;  pc_enable = 1'b1;
        end
      end
      S_T7: begin
        run = 1'b1;
        if (is_ld) begin
          mdr_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
        end else if (is_st) begin
          ram_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed vector table plus hand sequences for
// control_sequencer (reset hold, st abort, clr held, halt and restart).
module tb_control_sequencer;

  localparam int unsigned HOLD = 2;

  localparam logic [26:0] M_PC_OUT  = 27'h1 << 26;
  localparam logic [26:0] M_ZLO     = 27'h1 << 25;
  localparam logic [26:0] M_HI_OUT  = 27'h1 << 23;
  localparam logic [26:0] M_LO_OUT  = 27'h1 << 22;
  localparam logic [26:0] M_MDR_OUT = 27'h1 << 21;
  localparam logic [26:0] M_INPORT  = 27'h1 << 20;
  localparam logic [26:0] M_CSE     = 27'h1 << 19;
  localparam logic [26:0] M_BA      = 27'h1 << 18;
  localparam logic [26:0] M_R_OUT   = 27'h1 << 17;
  localparam logic [26:0] M_R_IN    = 27'h1 << 16;
  localparam logic [26:0] M_GRA     = 27'h1 << 15;
  localparam logic [26:0] M_GRB     = 27'h1 << 14;
  localparam logic [26:0] M_GRC     = 27'h1 << 13;
  localparam logic [26:0] M_MAR_EN  = 27'h1 << 12;
  localparam logic [26:0] M_MDR_EN  = 27'h1 << 11;
  localparam logic [26:0] M_IR_EN   = 27'h1 << 10;
  localparam logic [26:0] M_Y_EN    = 27'h1 << 9;
  localparam logic [26:0] M_Z_EN    = 27'h1 << 8;
  localparam logic [26:0] M_PC_EN   = 27'h1 << 7;
  localparam logic [26:0] M_PC_INC  = 27'h1 << 6;
  localparam logic [26:0] M_OUTPORT = 27'h1 << 3;
  localparam logic [26:0] M_CON_EN  = 27'h1 << 2;
  localparam logic [26:0] M_READ    = 27'h1 << 1;
  localparam logic [26:0] M_RAM_WR  = 27'h1 << 0;

  localparam logic [26:0] F0 = M_PC_OUT | M_MAR_EN | M_PC_INC | M_Z_EN;
  localparam logic [26:0] F1 = M_ZLO | M_PC_EN | M_READ | M_MDR_EN;
  localparam logic [26:0] F2 = M_MDR_OUT | M_IR_EN;
  localparam logic [26:0] Z  = 27'h0;

  localparam logic [31:0] GARB    = 32'hFFFF_FFFF;
  localparam logic [31:0] LDI_IR  = 32'h0900_0095;
  localparam logic [31:0] LD_IR   = 32'h0000_0000;
  localparam logic [31:0] ST_IR   = 32'h1000_0000;
  localparam logic [31:0] ADD_IR  = 32'h1800_0000;
  localparam logic [31:0] SUB_IR  = 32'h2000_0000;
  localparam logic [31:0] ADDI_IR = 32'h6000_0000;
  localparam logic [31:0] BR_IR   = 32'h9A80_0014;
  localparam logic [31:0] IN_IR   = 32'hB000_0000;
  localparam logic [31:0] OUT_IR  = 32'hB980_0000;
  localparam logic [31:0] MFHI_IR = 32'hC000_0000;
  localparam logic [31:0] MFLO_IR = 32'hC800_0000;
  localparam logic [31:0] NOP_IR  = 32'hD000_0000;
  localparam logic [31:0] HALT_IR = 32'hD800_0000;
  localparam logic [31:0] UND_IR  = 32'hF800_0000;

  logic clk = 1'b0;
  logic clr, con_out;
  logic [31:0] ir;
  logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out;
  logic c_sign_extended_out, ba_out, r_out, r_in, gra, grb, grc;
  logic mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable;
  logic pc_increment, hi_enable, lo_enable, outport_enable, con_enable;
  logic read, ram_write, run;
  logic [4:0] alu_op;
  logic [26:0] strb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_sequencer #(.RESET_PC_HOLD(HOLD)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_out(con_out),
    .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_out(hi_out),
    .lo_out(lo_out), .mdr_out(mdr_out), .inport_out(inport_out),
    .c_sign_extended_out(c_sign_extended_out), .ba_out(ba_out),
    .r_out(r_out), .r_in(r_in), .gra(gra), .grb(grb), .grc(grc),
    .mar_enable(mar_enable), .mdr_enable(mdr_enable), .ir_enable(ir_enable),
    .y_enable(y_enable), .z_enable(z_enable), .pc_enable(pc_enable),
    .pc_increment(pc_increment), .hi_enable(hi_enable), .lo_enable(lo_enable),
    .outport_enable(outport_enable), .con_enable(con_enable),
    .read(read), .ram_write(ram_write), .alu_op(alu_op), .run(run)
  );

  assign strb = {pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out,
                 c_sign_extended_out, ba_out, r_out, r_in, gra, grb, grc,
                 mar_enable, mdr_enable, ir_enable, y_enable, z_enable,
                 pc_enable, pc_increment, hi_enable, lo_enable, outport_enable,
                 con_enable, read, ram_write};

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        con;
    logic [26:0] s;
    logic [4:0]  a;
    logic        r;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [26:0] es,
                     input logic [4:0] ea, input logic er);
    checks++;
    if (strb !== es || alu_op !== ea || run !== er) begin
      errors++;
      $display("FAIL %s: got strobes=%h alu_op=%b run=%b, want strobes=%h alu_op=%b run=%b",
               name, strb, alu_op, run, es, ea, er);
    end
  endtask

  task automatic chk_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Advance one clock, then drive inputs for the new cycle and settle.
  task automatic tick(input logic [31:0] i, input logic c);
    @(posedge clk);
    #1;
    ir = i;
    con_out = c;
    #1;
  endtask

  // Run until T0 (pc_increment strobe) within a bound; report edges taken.
  task automatic wait_t0(input string name, input int want);
    int n;
    n = 0;
    do begin
      tick(NOP_IR, 1'b0);
      n++;
    end while (!(pc_out && pc_increment) && n < 12);
    chk_val(name, n, want);
  endtask

  task automatic add(input string n, input logic [31:0] i, input logic c,
                     input logic [26:0] s, input logic [4:0] a, input logic r);
    tbl.push_back('{n, i, c, s, a, r});
  endtask

  // Fetch rows; IR content only matters from T2/T3 onward.
  task automatic add_fetch(input string n, input logic [31:0] i);
    add({n, "_t0"}, GARB, 1'b0, F0, 5'd0, 1'b1);
    add({n, "_t1"}, GARB, 1'b0, F1, 5'd0, 1'b1);
    add({n, "_t2"}, i,    1'b0, F2, 5'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int rw;
    int n;
    int bad;

    clr = 1'b1;
    ir = '0;
    con_out = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    #1 chk("reset_state", Z, 5'd0, 1'b0);

    for (int i = 0; i < int'(HOLD); i++) add("reset_hold", GARB, 1'b0, Z, 5'd0, 1'b0);

    add_fetch("ldi", LDI_IR);
    add("ldi_t3", LDI_IR, 1'b0, M_GRB | M_BA | M_Y_EN, 5'd0, 1'b1);
    add("ldi_t4", GARB, 1'b0, M_CSE | M_Z_EN, 5'b00011, 1'b1);
    add("ldi_t5", GARB, 1'b0, M_ZLO | M_GRA | M_R_IN, 5'b00011, 1'b1);

    add_fetch("out", OUT_IR);
    add("out_t3", OUT_IR, 1'b0, M_GRA | M_R_OUT | M_OUTPORT, 5'd0, 1'b1);

    add_fetch("br1", BR_IR);
    add("br1_t3", BR_IR, 1'b0, M_GRA | M_R_OUT | M_CON_EN, 5'd0, 1'b1);
    add("br1_t4", GARB, 1'b0, M_PC_OUT | M_Y_EN, 5'b00011, 1'b1);
    add("br1_t5", GARB, 1'b0, M_CSE | M_Z_EN, 5'b00011, 1'b1);
    add("br1_t6", GARB, 1'b1, M_ZLO | M_PC_EN, 5'd0, 1'b1);

    add_fetch("br0", BR_IR);
    add("br0_t3", BR_IR, 1'b1, M_GRA | M_R_OUT | M_CON_EN, 5'd0, 1'b1);
    add("br0_t4", GARB, 1'b1, M_PC_OUT | M_Y_EN, 5'b00011, 1'b1);
    add("br0_t5", GARB, 1'b1, M_CSE | M_Z_EN, 5'b00011, 1'b1);
    add("br0_t6", GARB, 1'b0, Z, 5'd0, 1'b1);

    add_fetch("und", UND_IR);
    add("und_t3", UND_IR, 1'b0, Z, 5'd0, 1'b1);

    add_fetch("nop", NOP_IR);
    add("nop_t3", NOP_IR, 1'b0, Z, 5'd0, 1'b1);

    add_fetch("st", ST_IR);
    add("st_t3", ST_IR, 1'b0, M_GRB | M_BA | M_Y_EN, 5'd0, 1'b1);
    add("st_t4", GARB, 1'b0, M_CSE | M_Z_EN, 5'b00011, 1'b1);
    add("st_t5", GARB, 1'b0, M_ZLO | M_MAR_EN, 5'b00011, 1'b1);
    add("st_t6", GARB, 1'b0, M_GRA | M_R_OUT | M_MDR_EN, 5'd0, 1'b1);
    add("st_t7", GARB, 1'b0, M_RAM_WR, 5'd0, 1'b1);

    add_fetch("ld", LD_IR);
    add("ld_t3", LD_IR, 1'b0, M_GRB | M_BA | M_Y_EN, 5'd0, 1'b1);
    add("ld_t4", GARB, 1'b0, M_CSE | M_Z_EN, 5'b00011, 1'b1);
    add("ld_t5", GARB, 1'b0, M_ZLO | M_MAR_EN, 5'b00011, 1'b1);
    add("ld_t6", GARB, 1'b0, M_READ | M_MDR_EN, 5'd0, 1'b1);
    add("ld_t7", GARB, 1'b0, M_MDR_OUT | M_GRA | M_R_IN, 5'd0, 1'b1);

    add_fetch("add", ADD_IR);
    add("add_t3", ADD_IR, 1'b0, M_GRB | M_R_OUT | M_Y_EN, 5'd0, 1'b1);
    add("add_t4", GARB, 1'b0, M_GRC | M_R_OUT | M_Z_EN, 5'b00011, 1'b1);
    add("add_t5", GARB, 1'b0, M_ZLO | M_GRA | M_R_IN, 5'd0, 1'b1);

    add_fetch("sub", SUB_IR);
    add("sub_t3", SUB_IR, 1'b0, M_GRB | M_R_OUT | M_Y_EN, 5'd0, 1'b1);
    add("sub_t4", GARB, 1'b0, M_GRC | M_R_OUT | M_Z_EN, 5'b00100, 1'b1);
    add("sub_t5", GARB, 1'b0, M_ZLO | M_GRA | M_R_IN, 5'd0, 1'b1);

    add_fetch("addi", ADDI_IR);
    add("addi_t3", ADDI_IR, 1'b0, M_GRB | M_R_OUT | M_Y_EN, 5'd0, 1'b1);
    add("addi_t4", GARB, 1'b0, M_CSE | M_Z_EN, 5'b01100, 1'b1);
    add("addi_t5", GARB, 1'b0, M_ZLO | M_GRA | M_R_IN, 5'd0, 1'b1);

    add_fetch("in", IN_IR);
    add("in_t3", IN_IR, 1'b0, M_INPORT | M_GRA | M_R_IN, 5'd0, 1'b1);
    add_fetch("mfhi", MFHI_IR);
    add("mfhi_t3", MFHI_IR, 1'b0, M_HI_OUT | M_GRA | M_R_IN, 5'd0, 1'b1);
    add_fetch("mflo", MFLO_IR);
    add("mflo_t3", MFLO_IR, 1'b0, M_LO_OUT | M_GRA | M_R_IN, 5'd0, 1'b1);

    foreach (tbl[k]) begin
      tick(tbl[k].ir, tbl[k].con);
      chk(tbl[k].name, tbl[k].s, tbl[k].a, tbl[k].r);
    end

    // st aborted by clr in T6: no write afterwards, clean RESET.
    for (int i = 0; i < 7; i++) tick(ST_IR, 1'b0);
    chk("st_abort_t6", M_GRA | M_R_OUT | M_MDR_EN, 5'd0, 1'b1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    ir = NOP_IR;
    #1 chk("st_abort_reset", Z, 5'd0, 1'b0);
    rw = 0;
    n = 0;
    do begin
      tick(NOP_IR, 1'b0);
      n++;
      if (ram_write === 1'b1) rw++;
    end while (!(pc_out && pc_increment) && n < 12);
    chk_val("st_abort_t0_latency", n, int'(HOLD) + 1);
    for (int i = 0; i < 3; i++) begin
      tick(NOP_IR, 1'b0);
      if (ram_write === 1'b1) rw++;
    end
    chk_val("st_abort_no_ram_write", rw, 0);

    // clr held several cycles mid-fetch: counter reloads each time.
    tick(NOP_IR, 1'b0);
    chk("pre_hold_t0", F0, 5'd0, 1'b1);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2 chk("clr_held", Z, 5'd0, 1'b0);
    end
    clr = 1'b0;
    wait_t0("clr_held_t0_latency", int'(HOLD) + 1);

    // halt: run falls after T2 and stays low until clr.
    tick(GARB, 1'b0);
    chk("halt_t1", F1, 5'd0, 1'b1);
    tick(HALT_IR, 1'b0);
    chk("halt_t2", F2, 5'd0, 1'b1);
    tick(HALT_IR, 1'b0);
    chk("halt_t3", Z, 5'd0, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick($urandom, 1'($urandom));
      if (strb !== Z || alu_op !== 5'd0 || run !== 1'b0) bad++;
    end
    chk_val("halt_idle_20", bad, 0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    #1 chk("halt_clr_reset", Z, 5'd0, 1'b0);
    wait_t0("halt_restart_latency", int'(HOLD) + 1);
    chk("halt_restart_t0", F0, 5'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
